// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture engine: pixel format codes, FSM states,
// synchroniser depth, control-bus bit positions and the byte-pair to pixel packer.
// No logic of its own; no latency, no backpressure.
package cam_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam int FMT_RGB565 = 0;
  localparam int FMT_RGB444 = 1;
  localparam int FMT_Y8     = 2;

  // Bit positions of the camera control lines inside the shared synchroniser.
  localparam int CTL_HREF  = 0;
  localparam int CTL_VSYNC = 1;
  localparam int CTL_PCLK  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_CAPTURE,
    ST_DONE
  } cam_state_t;

  // Packs the first byte b0 and second byte b1 into a pixel, right-aligned in 12 bits.
  function automatic logic [11:0] cam_pix(int fmt, logic [7:0] b0, logic [7:0] b1);
    logic [11:0] p;
    logic        unused_b0;
    p         = '0;
    unused_b0 = b0[4];
    case (fmt)
      FMT_RGB444: p = {b0[3:0], b1};
      FMT_Y8:     p = {4'h0, b0[7:5], b0[7:5], b0[7:6]};
      default:    p = {4'h0, b0[7:5], b0[2:0], b1[4:3]};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cam_frame_capture_if.sv
// Frame-buffer write port: address, pixel and one-cycle write strobe.
// Pure wiring, no latency.
// No backpressure: the RAM side must accept every strobe.
interface cam_frame_capture_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  modport master (output wr_addr, output wr_data, output wr_en);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/cam_sync.sv
// Multi-bit 2-FF synchroniser with rise/fall detection on the synchronised value.
// Latency: q follows d after SYNC_DEPTH clocks; edge flags are combinational on q.
// No backpressure.
module cam_sync
  import cam_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [SYNC_DEPTH-1:0][W-1:0] stg;
  logic [W-1:0]                 q_prev;

  // Shift the raw input through the synchroniser and keep one more copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg    <= '0;
      q_prev <= '0;
    end else begin
      stg    <= {stg[SYNC_DEPTH-2:0], d};
      q_prev <= stg[SYNC_DEPTH-1];
    end
  end

  assign q    = stg[SYNC_DEPTH-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670-style capture: samples Href/Vsync/Pclk/D as data and emits frame-buffer writes.
// Latency: write strobe 3 clk after the Pclk pin edge completing a pixel; optional frame_cnt (CAM_FRAME_CNT_EN).
// No backpressure: every in-range pixel is written; out-of-range pixels are dropped.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int PIX_FMT      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_en,
  input  logic                 Href,
  input  logic                 Vsync,
  input  logic                 Pclk,
  input  logic [7:0]           D,
  cam_frame_capture_if.master  wr,
  output logic                 frame_done,
  output logic                 line_err,
  output logic                 busy
`ifdef CAM_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int XW = $clog2(CAM_SCREEN_X + 1);
  localparam int YW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [XW-1:0] X_MAX = XW'(CAM_SCREEN_X);
  localparam logic [YW-1:0] Y_MAX = YW'(CAM_SCREEN_Y);

  cam_state_t state_q, state_d;

  logic [2:0]    ctl_s, ctl_rise, ctl_fall;
  logic [7:0]    d_s, d_rise_unused, d_fall_unused;
  logic          href_s, href_fall, vs_rise, vs_fall, pclk_rise;
  logic          in_capture, frame_start, byte_ev, line_end;
  logic          phase_q;
  logic [7:0]    b0_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [11:0]   pix;
  logic [31:0]   addr_full;
  logic          unused_bits;

  cam_sync #(.W(3)) u_ctl_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({Pclk, Vsync, Href}),
    .q    (ctl_s),
    .rise (ctl_rise),
    .fall (ctl_fall)
  );

  cam_sync #(.W(8)) u_dat_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (D),
    .q    (d_s),
    .rise (d_rise_unused),
    .fall (d_fall_unused)
  );

  assign href_s    = ctl_s[CTL_HREF];
  assign href_fall = ctl_fall[CTL_HREF];
  assign vs_rise   = ctl_rise[CTL_VSYNC];
  assign vs_fall   = ctl_fall[CTL_VSYNC];
  assign pclk_rise = ctl_rise[CTL_PCLK];

  // A Vsync rise ends the frame, so bytes and line ends in that same cycle are ignored.
  assign in_capture  = (state_q == ST_CAPTURE);
  assign frame_start = (state_q == ST_WAIT_FRAME) && vs_fall;
  assign byte_ev     = in_capture && pclk_rise && href_s && !vs_rise;
  assign line_end    = in_capture && href_fall && !vs_rise;

  assign pix       = cam_pix(PIX_FMT, b0_q, d_s);
  assign addr_full = 32'(y_q) * 32'(CAM_SCREEN_X) + 32'(x_q);

  // Bits not consumed: unused edge flags, pixel bits above DW, address bits above AW.
  assign unused_bits = ^{ctl_s[CTL_VSYNC], ctl_s[CTL_PCLK], ctl_rise[CTL_HREF],
                         ctl_fall[CTL_PCLK], pix, addr_full};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; capture_en only matters at frame boundaries (IDLE and DONE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (capture_en) state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (vs_fall)    state_d = ST_CAPTURE;
      ST_CAPTURE:    if (vs_rise)    state_d = ST_DONE;
      ST_DONE:       state_d = capture_en ? ST_WAIT_FRAME : ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  assign frame_done = (state_q == ST_DONE);
  assign busy       = (state_q == ST_WAIT_FRAME) || (state_q == ST_CAPTURE);

  // Byte pairing, x/y tracking and registered write port; outputs hold when not writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      b0_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      line_err   <= 1'b0;
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
    end else begin
      wr.wr_en <= 1'b0;
      line_err <= 1'b0;
      if (!in_capture) begin
        // Leaving capture (incl. Vsync mid-line) drops any half pixel silently.
        phase_q <= 1'b0;
        if (frame_start) begin
          x_q <= '0;
          y_q <= '0;
        end
      end else if (line_end) begin
        line_err <= phase_q;
        phase_q  <= 1'b0;
        x_q      <= '0;
        // x is non-zero exactly when the line completed at least one pixel.
        if (x_q != '0 && y_q < Y_MAX) y_q <= y_q + 1'b1;
      end else if (byte_ev) begin
        if (!phase_q) begin
          b0_q    <= d_s;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (x_q < X_MAX && y_q < Y_MAX) begin
            wr.wr_en   <= 1'b1;
            wr.wr_addr <= addr_full[AW-1:0];
            wr.wr_data <= pix[DW-1:0];
          end
          if (x_q < X_MAX) x_q <= x_q + 1'b1;
        end
      end
    end
  end

`ifdef CAM_FRAME_CNT_EN
  // Count completed frames; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                    frame_cnt <= '0;
    else if (state_q == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: three format variants share one camera bus,
// directed frames plus random frames, checked against a line-level reference model.
module tb_cam_frame_capture;
  import cam_pkg::*;

  localparam int X = 4;
  localparam int Y = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       capture_en = 1'b0;
  logic       Href = 1'b0;
  logic       Vsync = 1'b1;
  logic       Pclk = 1'b0;
  logic [7:0] D = 8'h00;
  logic [2:0] fd, le, bz;

  always #5 clk = ~clk;

  cam_frame_capture_if #(.AW(4), .DW(8))  w0 ();
  cam_frame_capture_if #(.AW(4), .DW(12)) w1 ();
  cam_frame_capture_if #(.AW(4), .DW(8))  w2 ();

`ifdef CAM_FRAME_CNT_EN
  logic [15:0] fc0, fc1, fc2;
`endif

  cam_frame_capture #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(4), .DW(8), .PIX_FMT(FMT_RGB565)) u0 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .Href(Href), .Vsync(Vsync), .Pclk(Pclk), .D(D),
    .wr(w0.master), .frame_done(fd[0]), .line_err(le[0]), .busy(bz[0])
`ifdef CAM_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );
  cam_frame_capture #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(4), .DW(12), .PIX_FMT(FMT_RGB444)) u1 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .Href(Href), .Vsync(Vsync), .Pclk(Pclk), .D(D),
    .wr(w1.master), .frame_done(fd[1]), .line_err(le[1]), .busy(bz[1])
`ifdef CAM_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );
  cam_frame_capture #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(4), .DW(8), .PIX_FMT(FMT_Y8)) u2 (
    .clk(clk), .rst(rst), .capture_en(capture_en), .Href(Href), .Vsync(Vsync), .Pclk(Pclk), .D(D),
    .wr(w2.master), .frame_done(fd[2]), .line_err(le[2]), .busy(bz[2])
`ifdef CAM_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference pixel conversion using plain arithmetic on the colour components.
  function automatic int conv(input int fmt, input int b0, input int b1);
    int r, g, b, yv;
    if (fmt == FMT_RGB444) return (b0 % 16) * 256 + b1;
    if (fmt == FMT_Y8) begin
      yv = b0 / 32;
      return yv * 32 + yv * 4 + b0 / 64;
    end
    r = b0 / 8;
    g = (b0 % 8) * 8 + b1 / 32;
    b = b1 % 32;
    return (r / 4) * 32 + (g / 8) * 4 + b / 8;
  endfunction

  // Observed activity, collected on the falling edge.
  int cyc = 0;
  int last_pclk_cyc = 0;
  int act [3][$];
  int n_err [3];
  int n_fd [3];
  int n_bad = 0;
  logic [2:0] prev_wr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [2:0] we;
    we = {w2.wr_en, w1.wr_en, w0.wr_en};
    if (we[0]) begin
      act[0].push_back(int'(w0.wr_addr) * 65536 + int'(w0.wr_data));
      chk("wr_latency", cyc - last_pclk_cyc, 3);
    end
    if (we[1]) act[1].push_back(int'(w1.wr_addr) * 65536 + int'(w1.wr_data));
    if (we[2]) act[2].push_back(int'(w2.wr_addr) * 65536 + int'(w2.wr_data));
    for (int k = 0; k < 3; k++) begin
      n_err[k] += int'(le[k]);
      n_fd[k]  += int'(fd[k]);
      if ((fd[k] && we[k]) || (we[k] && prev_wr[k])) n_bad++;
    end
    prev_wr = we;
  end

  int         lens[$];
  logic [7:0] bytes_q[$];
  int         exp_q [3][$];
  int         e_err;
  int         frames_exp = 0;

  task automatic build_exp(input bit cap, input bit abort_last);
    int yy, idx, np;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    e_err = 0;
    if (!cap) return;
    yy = 0;
    idx = 0;
    for (int l = 0; l < lens.size(); l++) begin
      np = lens[l] / 2;
      for (int p = 0; p < np; p++)
        if (p < X && yy < Y) begin
          exp_q[0].push_back((yy * X + p) * 65536 + conv(FMT_RGB565, bytes_q[idx+2*p], bytes_q[idx+2*p+1]));
          exp_q[1].push_back((yy * X + p) * 65536 + conv(FMT_RGB444, bytes_q[idx+2*p], bytes_q[idx+2*p+1]));
          exp_q[2].push_back((yy * X + p) * 65536 + conv(FMT_Y8,     bytes_q[idx+2*p], bytes_q[idx+2*p+1]));
        end
      if ((lens[l] % 2) == 1 && !(abort_last && l == lens.size() - 1)) e_err++;
      if (np > 0 && yy < Y) yy++;
      idx += lens[l];
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); D = b; Pclk = 1'b0;
    @(negedge clk);
    @(negedge clk); Pclk = 1'b1; last_pclk_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic run_frame(input bit cap, input bit abort_last, input bit drop_en);
    int idx;
    for (int k = 0; k < 3; k++) begin
      act[k].delete();
      n_err[k] = 0;
      n_fd[k] = 0;
    end
    n_bad = 0;
    build_exp(cap, abort_last);
    if (cap) frames_exp++;
    repeat (6) @(negedge clk);
    Vsync = 1'b0;
    repeat (4) @(negedge clk);
    idx = 0;
    for (int l = 0; l < lens.size(); l++) begin
      Href = 1'b1;
      @(negedge clk);
      for (int i = 0; i < lens[l]; i++) send_byte(bytes_q[idx + i]);
      idx += lens[l];
      if (l == 0 && drop_en) capture_en = 1'b0;
      @(negedge clk);
      Pclk = 1'b0;
      if (abort_last && l == lens.size() - 1) begin
        Vsync = 1'b1;
        repeat (5) @(negedge clk);
      end
      Href = 1'b0;
      repeat (4) @(negedge clk);
    end
    Vsync = 1'b1;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("nwr%0d", k), act[k].size(), exp_q[k].size());
      for (int i = 0; i < exp_q[k].size() && i < act[k].size(); i++)
        chk($sformatf("wr%0d_%0d", k, i), act[k][i], exp_q[k][i]);
      chk($sformatf("line_err%0d", k), n_err[k], e_err);
      chk($sformatf("frame_done%0d", k), n_fd[k], int'(cap));
    end
    chk("wr_overlap", n_bad, 0);
`ifdef CAM_FRAME_CNT_EN
    chk("frame_cnt", fc0, frames_exp);
`endif
  endtask

  task automatic set_line(input int n, input logic [7:0] b0, input logic [7:0] b1);
    lens.push_back(n);
    for (int i = 0; i < n; i++) bytes_q.push_back((i % 2 == 0) ? b0 : b1);
  endtask

  task automatic clear_frame();
    lens.delete();
    bytes_q.delete();
  endtask

  initial begin
    // Reset held with the camera bus toggling: nothing may come out.
    capture_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      Href  = 1'($urandom_range(0, 1));
      Vsync = 1'($urandom_range(0, 1));
      Pclk  = 1'($urandom_range(0, 1));
      D     = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    Href = 1'b0; Vsync = 1'b1; Pclk = 1'b0;
    chk("rst_nwr", act[0].size() + act[1].size() + act[2].size(), 0);
    chk("rst_busy", bz, 0);
    chk("rst_done", fd, 0);
    chk("rst_lerr", le, 0);
    chk("rst_wr", {w0.wr_en, w0.wr_addr, w0.wr_data, w1.wr_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_armed", bz, 3'b111);

    // Two lines of {F8,00}: eight writes of E0 at addresses 0..7.
    clear_frame(); set_line(8, 8'hF8, 8'h00); set_line(8, 8'hF8, 8'h00);
    run_frame(1, 0, 0);
    chk("rgb565_first", act[0].size() > 0 ? act[0][0] : -1, 32'h0000_00E0);
    chk("rgb565_last",  act[0].size() > 7 ? act[0][7] : -1, 32'h0007_00E0);

    // Format examples: {0A,BC} -> ABC in RGB444, {80,55} -> 92 as grey.
    clear_frame(); lens.push_back(4);
    bytes_q.push_back(8'h0A); bytes_q.push_back(8'hBC); bytes_q.push_back(8'h80); bytes_q.push_back(8'h55);
    run_frame(1, 0, 0);
    chk("rgb444_abc", act[1].size() > 0 ? act[1][0] : -1, 32'h0000_0ABC);
    chk("y8_92",      act[2].size() > 1 ? act[2][1] : -1, 32'h0001_0092);

    // Six-pixel line on a four-pixel screen, then a normal line starting at 4.
    clear_frame(); set_line(12, 8'h3C, 8'hA5); set_line(8, 8'hC3, 8'h5A);
    run_frame(1, 0, 0);

    // Odd-length line: three writes, one line_err, y still advances.
    clear_frame(); set_line(7, 8'h12, 8'h34); set_line(4, 8'h56, 8'h78);
    run_frame(1, 0, 0);

    // Vsync rises mid-line on an odd byte: half pixel dropped, no line_err.
    clear_frame(); set_line(4, 8'h9A, 8'hBC); set_line(5, 8'hDE, 8'hF0);
    run_frame(1, 1, 0);

    // capture_en dropped mid-frame: frame completes, then engine idles.
    clear_frame(); set_line(4, 8'h11, 8'h22); set_line(4, 8'h33, 8'h44);
    run_frame(1, 0, 1);
    chk("idle_after_drop", bz, 0);
    run_frame(0, 0, 0);
    capture_en = 1'b1;
    repeat (3) @(negedge clk);

    // Random frames: varied line counts, lengths (incl. empty and odd) and data.
    for (int f = 0; f < 12; f++) begin
      int nl, n;
      bit ab;
      clear_frame();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        n = $urandom_range(0, 13);
        lens.push_back(n);
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      end
      ab = ($urandom_range(0, 3) == 0);
      run_frame(1, ab, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
